// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared state encoding, opcode classes and IR field positions for the ALU instruction sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_DONE
  } state_t;

  localparam logic [4:0] OP_LAST_NARROW = 5'b01110;
  localparam logic [4:0] OP_MUL         = 5'b01111;
  localparam logic [4:0] OP_DIV         = 5'b10000;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  // MUL and DIV produce a 64-bit result that lands in LO and HI.
  function automatic logic op_is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Everything above DIV has no ALU meaning.
  function automatic logic op_is_illegal(input logic [4:0] op);
    return op > OP_DIV;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Purpose: 4-bit register field plus enable to a 16-bit one-hot R0..R15 select.
// Latency: combinational.
// Backpressure: none.
module reg_sel_decoder (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  // Shift a single one into the selected slot; all zero when disabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Purpose: control FSM sequencing fetch, decode, operand load, ALU compute and writeback of one R-type instruction.
// Latency: start to done = 5+MEM_WAIT+1 cycles (narrow), 5+MEM_WAIT+WIDE_LAT+1 cycles (MUL/DIV).
// Backpressure: none; start is only looked at in IDLE and ignored while busy.
import cpu_ctrl_pkg::*;

module alu_instr_sequencer #(
  parameter int MEM_WAIT = 1,
  parameter int WIDE_LAT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic [4:0]  ALU_opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [7:0] MW_LOAD = 8'(MEM_WAIT - 1);
  localparam logic [7:0] WL_LOAD = 8'(WIDE_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  op_q;
  logic [3:0]  ra_q, rb_q, rc_q;
  logic        illegal_q;
  logic        ra_en, rb_en, rc_en;
  logic [15:0] rout_b, rout_c;
  logic        wide_op;
  logic        unused_ir_bits;

  assign wide_op        = op_is_wide(op_q);
  assign unused_ir_bits = ^ir[14:0];

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: dwell states leave when the counter reaches zero; decode happens as T2 ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (cnt_q == 8'd0) state_d = ST_T2;
      ST_T2:   state_d = op_is_illegal(ir[IR_OP_HI:IR_OP_LO]) ? ST_IDLE : ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4:   if (cnt_q == 8'd0) state_d = ST_T5;
      ST_T5:   state_d = wide_op ? ST_T6 : ST_DONE;
      ST_T6:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Dwell counter: loaded on entry to T1/T4, counts down to zero and parks there.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_T1:   cnt_d = MW_LOAD;
        ST_T4:   cnt_d = wide_op ? WL_LOAD : 8'd0;
        default: cnt_d = 8'd0;
      endcase
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  // Capture the IR fields as T2 ends so every later output is a pure function of registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q <= 5'd0;
      ra_q <= 4'd0;
      rb_q <= 4'd0;
      rc_q <= 4'd0;
    end else if (state_q == ST_T2) begin
      op_q <= ir[IR_OP_HI:IR_OP_LO];
      ra_q <= ir[IR_RA_HI:IR_RA_LO];
      rb_q <= ir[IR_RB_HI:IR_RB_LO];
      rc_q <= ir[IR_RC_HI:IR_RC_LO];
    end
  end

  // Illegal flag pulses for the single IDLE cycle that follows a rejected decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) illegal_q <= 1'b0;
    else     illegal_q <= (state_q == ST_T2) && op_is_illegal(ir[IR_OP_HI:IR_OP_LO]);
  end

  reg_sel_decoder u_rin_ra (.en_i(ra_en), .sel_i(ra_q), .onehot_o(Rin));
  reg_sel_decoder u_rout_rb (.en_i(rb_en), .sel_i(rb_q), .onehot_o(rout_b));
  reg_sel_decoder u_rout_rc (.en_i(rc_en), .sel_i(rc_q), .onehot_o(rout_c));

  // T3 and T4 are the only register-drive states, so the two Rout selects never overlap.
  assign Rout = rout_b | rout_c;

  // Moore output decode; exactly one bus driver per state.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRread    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    ZLOout     = 1'b0;
    ZHIout     = 1'b0;
    HIin       = 1'b0;
    Loin       = 1'b0;
    ALU_opcode = 5'b00000;
    ra_en      = 1'b0;
    rb_en      = 1'b0;
    rc_en      = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    illegal    = illegal_q;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        ZLOout  = 1'b1;
        PCin    = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        rb_en = 1'b1;
        Yin   = 1'b1;
      end
      ST_T4: begin
        rc_en      = 1'b1;
        Zin        = 1'b1;
        ALU_opcode = op_q;
      end
      ST_T5: begin
        ZLOout = 1'b1;
        if (wide_op) Loin  = 1'b1;
        else         ra_en = 1'b1;
      end
      ST_T6: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Purpose: directed table-driven bench for alu_instr_sequencer plus hand-written reset/back-to-back/wait sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        use_b = 1'b0;

  logic [15:0] Rin_a, Rout_a, Rin_b, Rout_b;
  logic PCout_a, PCin_a, IncPC_a, MARin_a, MDRread_a, MDRin_a, MDRout_a, IRin_a;
  logic Yin_a, Zin_a, ZLOout_a, ZHIout_a, HIin_a, Loin_a, busy_a, done_a, illegal_a;
  logic PCout_b, PCin_b, IncPC_b, MARin_b, MDRread_b, MDRin_b, MDRout_b, IRin_b;
  logic Yin_b, Zin_b, ZLOout_b, ZHIout_b, HIin_b, Loin_b, busy_b, done_b, illegal_b;
  logic [4:0] op_a, op_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_instr_sequencer #(.MEM_WAIT(1), .WIDE_LAT(4)) dut_a (
    .clk(clk), .clr(clr), .start(start_a), .ir(ir),
    .Rin(Rin_a), .Rout(Rout_a), .PCout(PCout_a), .PCin(PCin_a), .IncPC(IncPC_a), .MARin(MARin_a),
    .MDRread(MDRread_a), .MDRin(MDRin_a), .MDRout(MDRout_a), .IRin(IRin_a), .Yin(Yin_a), .Zin(Zin_a),
    .ZLOout(ZLOout_a), .ZHIout(ZHIout_a), .HIin(HIin_a), .Loin(Loin_a), .ALU_opcode(op_a),
    .busy(busy_a), .done(done_a), .illegal(illegal_a)
  );

  alu_instr_sequencer #(.MEM_WAIT(3), .WIDE_LAT(1)) dut_b (
    .clk(clk), .clr(clr), .start(start_b), .ir(ir),
    .Rin(Rin_b), .Rout(Rout_b), .PCout(PCout_b), .PCin(PCin_b), .IncPC(IncPC_b), .MARin(MARin_b),
    .MDRread(MDRread_b), .MDRin(MDRin_b), .MDRout(MDRout_b), .IRin(IRin_b), .Yin(Yin_b), .Zin(Zin_b),
    .ZLOout(ZLOout_b), .ZHIout(ZHIout_b), .HIin(HIin_b), .Loin(Loin_b), .ALU_opcode(op_b),
    .busy(busy_b), .done(done_b), .illegal(illegal_b)
  );

  // Observation view of whichever instance is under test.
  logic [15:0] s_Rin, s_Rout;
  logic [4:0]  s_op;
  logic s_PCout, s_PCin, s_MDRread, s_Yin, s_Zin, s_ZLOout, s_HIin, s_Loin, s_busy, s_done, s_ill;
  logic [53:0] all_a, all_b;
  always_comb begin
    s_Rin     = use_b ? Rin_b     : Rin_a;
    s_Rout    = use_b ? Rout_b    : Rout_a;
    s_op      = use_b ? op_b      : op_a;
    s_PCout   = use_b ? PCout_b   : PCout_a;
    s_PCin    = use_b ? PCin_b    : PCin_a;
    s_MDRread = use_b ? MDRread_b : MDRread_a;
    s_Yin     = use_b ? Yin_b     : Yin_a;
    s_Zin     = use_b ? Zin_b     : Zin_a;
    s_ZLOout  = use_b ? ZLOout_b  : ZLOout_a;
    s_HIin    = use_b ? HIin_b    : HIin_a;
    s_Loin    = use_b ? Loin_b    : Loin_a;
    s_busy    = use_b ? busy_b    : busy_a;
    s_done    = use_b ? done_b    : done_a;
    s_ill     = use_b ? illegal_b : illegal_a;
    all_a = {Rin_a, Rout_a, PCout_a, PCin_a, IncPC_a, MARin_a, MDRread_a, MDRin_a, MDRout_a, IRin_a,
             Yin_a, Zin_a, ZLOout_a, ZHIout_a, HIin_a, Loin_a, op_a, busy_a, done_a, illegal_a};
    all_b = {Rin_b, Rout_b, PCout_b, PCin_b, IncPC_b, MARin_b, MDRread_b, MDRin_b, MDRout_b, IRin_b,
             Yin_b, Zin_b, ZLOout_b, ZHIout_b, HIin_b, Loin_b, op_b, busy_b, done_b, illegal_b};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Bus contention watch on both instances, every cycle.
  always @(negedge clk) begin
    if (!clr) begin
      chk("bus_a", ($countones({PCout_a, ZLOout_a, ZHIout_a, MDRout_a}) + $countones(Rout_a)) > 1, 0);
      chk("bus_b", ($countones({PCout_b, ZLOout_b, ZHIout_b, MDRout_b}) + $countones(Rout_b)) > 1, 0);
    end
  end

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra, rb, rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic [15:0] rout3;
    logic [15:0] rout4;
    logic [15:0] rin5;
    logic [4:0]  opc;
    int          zin4;
    bit          lo;
    bit          hi;
    bit          ill;
    int          lat;
  } vec_t;

  logic [15:0] o_rout3, o_rout4, o_rin5;
  logic [4:0]  o_opc;
  int          o_zin4, o_lat, o_mdr;
  bit          o_lo, o_hi, o_ill, o_yin, o_busy_ill;

  // Pulse start, then watch one instruction for up to 30 cycles; cycle 1 is T0.
  task automatic run_instr(input logic [31:0] iv);
    o_rout3 = 0; o_rout4 = 0; o_rin5 = 0; o_opc = 0; o_zin4 = 0; o_lat = 0; o_mdr = 0;
    o_lo = 0; o_hi = 0; o_ill = 0; o_yin = 0; o_busy_ill = 1;
    @(negedge clk);
    ir = iv;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (s_MDRread) o_mdr++;
      if (s_Yin) begin o_yin = 1; o_rout3 = s_Rout; end
      if (s_Zin && !s_PCout) begin o_zin4++; o_rout4 = s_Rout; o_opc = s_op; end
      if (s_ZLOout && !s_PCin) begin o_rin5 = s_Rin; o_lo = s_Loin; end
      if (s_HIin) o_hi = 1;
      if (s_done) begin o_lat = n; break; end
      if (s_ill) begin o_ill = 1; o_busy_ill = s_busy; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int pc1, pc2, d1, d2, npc, ndone;
    bit yin6;

    vecs[0] = '{32'h18918000, 16'h0004, 16'h0008, 16'h0002, 5'b00011, 1, 0, 0, 0, 7};
    vecs[1] = '{32'h80228000, 16'h0010, 16'h0020, 16'h0000, 5'b10000, 4, 1, 1, 0, 11};
    vecs[2] = '{32'hF8000000, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1, 0};
    vecs[3] = '{mk_ir(5'b01111, 4'd7, 4'd8, 4'd9), 16'h0100, 16'h0200, 16'h0000, 5'b01111, 4, 1, 1, 0, 11};
    vecs[4] = '{mk_ir(5'b01110, 4'd15, 4'd0, 4'd14), 16'h0001, 16'h4000, 16'h8000, 5'b01110, 1, 0, 0, 0, 7};
    vecs[5] = '{mk_ir(5'b10001, 4'd1, 4'd2, 4'd3), 16'h0000, 16'h0000, 16'h0000, 5'b00000, 0, 0, 0, 1, 0};
    vecs[6] = '{mk_ir(5'b00000, 4'd0, 4'd15, 4'd0), 16'h8000, 16'h0001, 16'h0001, 5'b00000, 1, 0, 0, 0, 7};

    // Reset state.
    #1;
    chk("reset_outputs_a", {10'd0, all_a}, 0);
    chk("reset_outputs_b", {10'd0, all_b}, 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Table vectors on the MEM_WAIT=1 / WIDE_LAT=4 instance.
    for (int i = 0; i < 7; i++) begin
      run_instr(vecs[i].ir);
      chk($sformatf("v%0d_rout_t3", i), o_rout3, vecs[i].rout3);
      chk($sformatf("v%0d_rout_t4", i), o_rout4, vecs[i].rout4);
      chk($sformatf("v%0d_rin_t5", i), o_rin5, vecs[i].rin5);
      chk($sformatf("v%0d_alu_op", i), o_opc, vecs[i].opc);
      chk($sformatf("v%0d_zin_cycles", i), o_zin4, vecs[i].zin4);
      chk($sformatf("v%0d_loin", i), o_lo, vecs[i].lo);
      chk($sformatf("v%0d_hiin", i), o_hi, vecs[i].hi);
      chk($sformatf("v%0d_illegal", i), o_ill, vecs[i].ill);
      chk($sformatf("v%0d_latency", i), o_lat, vecs[i].lat);
      chk($sformatf("v%0d_yin_seen", i), o_yin, !vecs[i].ill);
      if (vecs[i].ill) begin
        chk($sformatf("v%0d_busy_at_illegal", i), o_busy_ill, 0);
        chk($sformatf("v%0d_illegal_one_cycle", i), illegal_a, 0);
      end
    end

    // Asynchronous reset in the middle of a DIV's T4.
    @(negedge clk);
    ir = 32'h80228000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_in_t4", {busy_a, Zin_a, op_a}, {2'b11, 5'b10000});
    clr = 1'b1;
    #1;
    chk("midrun_reset_outputs", {10'd0, all_a}, 0);
    @(negedge clk);
    clr = 1'b0;
    run_instr(32'h18918000);
    chk("post_reset_latency", o_lat, 7);
    chk("post_reset_rin", o_rin5, 16'h0002);

    // MEM_WAIT=3 instance: memory wait length, and start during T3 must be ignored.
    use_b = 1'b1;
    o_mdr = 0; ndone = 0; d1 = 0; yin6 = 0;
    @(negedge clk);
    ir = 32'h18918000;
    start_b = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_b = (n == 6);
      if (MDRread_b && MDRin_b) o_mdr++;
      if (n == 6) yin6 = Yin_b;
      if (done_b) begin ndone++; if (d1 == 0) d1 = n; end
    end
    start_b = 1'b0;
    chk("mw3_mdr_cycles", o_mdr, 3);
    chk("mw3_t3_at_cycle6", yin6, 1);
    chk("mw3_done_count", ndone, 1);
    chk("mw3_latency", d1, 9);
    use_b = 1'b0;

    // Back-to-back: start held across two ADDs.
    pc1 = 0; pc2 = 0; d1 = 0; d2 = 0; npc = 0; ndone = 0;
    @(negedge clk);
    ir = 32'h18918000;
    start_a = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (PCout_a) begin
        npc++;
        if (npc == 1) pc1 = n;
        if (npc == 2) begin pc2 = n; start_a = 1'b0; end
      end
      if (done_a) begin
        ndone++;
        if (ndone == 1) d1 = n;
        if (ndone == 2) d2 = n;
      end
    end
    start_a = 1'b0;
    chk("b2b_first_t0", pc1, 1);
    chk("b2b_first_done", d1, 7);
    chk("b2b_second_t0", pc2, 9);
    chk("b2b_second_done", d2, 15);
    chk("b2b_fetch_count", npc, 2);
    chk("b2b_done_count", ndone, 2);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
